// File: rtl/sdp_y_arb_pkg.sv
// Shared types and defaults for the SDP Y mul-core output arbiter.
// Grant states are encoded so that a grant state can be built directly from a requester index.
package sdp_y_arb_pkg;

    parameter int unsigned DefWidth = 128;
    parameter int unsigned DefCntW  = 8;

    localparam logic Req0Idx = 1'b0;
    localparam logic Req1Idx = 1'b1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } arb_state_e;

    function automatic arb_state_e grant_state(input logic idx);
        return (idx == Req1Idx) ? StGrant1 : StGrant0;
    endfunction

endpackage

// File: rtl/sdp_y_out_stage.sv
// One-entry registered valid/ready output stage.
// A load always wins over a take, so back-to-back beats keep vld_o high.
module sdp_y_out_stage
    import sdp_y_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             take_i,
    input  logic [WIDTH-1:0] pd_i,
    input  logic             src_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] pd_o,
    output logic             src_o
);

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] pd_q, pd_d;
    logic             src_q, src_d;

    always_comb begin
        vld_d = vld_q;
        pd_d  = pd_q;
        src_d = src_q;
        if (load_i) begin
            vld_d = 1'b1;
            pd_d  = pd_i;
            src_d = src_i;
        end else if (take_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            pd_q  <= '0;
            src_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            pd_q  <= pd_d;
            src_q <= src_d;
        end
    end

    assign vld_o = vld_q;
    assign pd_o  = pd_q;
    assign src_o = src_q;

endmodule

// File: rtl/sdp_y_mul_out_arb.sv
// Two-requester round-robin burst arbiter for the SDP Y mul-core output channel.
// A grant is held for len_q+1 accepted beats regardless of gaps in the owner's valid.
module sdp_y_mul_out_arb
    import sdp_y_arb_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [CNT_W-1:0] cfg_burst_len,
    input  logic             req0_vld,
    output logic             req0_rdy,
    input  logic [WIDTH-1:0] req0_pd,
    input  logic             req1_vld,
    output logic             req1_rdy,
    input  logic [WIDTH-1:0] req1_pd,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_pd,
    output logic             out_src,
    output logic             arb_busy
);

    arb_state_e       state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             arb_busy_q;

    logic             stage_free;
    logic             grant_idx;
    logic             accept;
    logic             last_beat;
    logic [WIDTH-1:0] sel_pd;

    // Ready depends only on grant and output-stage occupancy, never on the requester's valid.
    assign stage_free = !out_vld || out_rdy;
    assign req0_rdy   = (state_q == StGrant0) && stage_free;
    assign req1_rdy   = (state_q == StGrant1) && stage_free;

    assign grant_idx = (state_q == StGrant1) ? Req1Idx : Req0Idx;
    assign accept    = (req0_vld && req0_rdy) || (req1_vld && req1_rdy);
    assign last_beat = accept && (beat_cnt_q == len_q);
    assign sel_pd    = (grant_idx == Req1Idx) ? req1_pd : req0_pd;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        unique case (state_q)
            StIdle: begin
                if (req0_vld || req1_vld) begin
                    if (req0_vld && req1_vld) begin
                        state_d = grant_state(rr_ptr_q);
                    end else if (req0_vld) begin
                        state_d = StGrant0;
                    end else begin
                        state_d = StGrant1;
                    end
                    len_d      = cfg_burst_len;
                    beat_cnt_d = '0;
                end
            end
            StGrant0, StGrant1: begin
                if (last_beat) begin
                    state_d    = StIdle;
                    rr_ptr_d   = !grant_idx;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= Req0Idx;
            beat_cnt_q <= '0;
            len_q      <= '0;
            arb_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            arb_busy_q <= (state_d != StIdle);
        end
    end

    assign arb_busy = arb_busy_q;

    sdp_y_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk_i  (nvdla_core_clk),
        .rst_i  (nvdla_core_rst),
        .load_i (accept),
        .take_i (out_rdy),
        .pd_i   (sel_pd),
        .src_i  (grant_idx),
        .vld_o  (out_vld),
        .pd_o   (out_pd),
        .src_o  (out_src)
    );

    a_cnt_in_range: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        beat_cnt_q <= len_q);

    a_single_grant: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(req0_rdy && req1_rdy));

endmodule

// File: doc/sdp_y_mul_out_arb.md
Name: sdp_y_mul_out_arb

Overview:
- Two-requester burst arbiter in front of the SDP Y mul-core output channel (chn_mul_out, 128-bit).
- Shares the single output channel between the mul datapath (req0) and the bypass/ALU-through path (req1).
- Uses round-robin grants, locked for a configurable burst of beats.
- Ends in a one-entry registered output stage with valid/ready semantics matching the output rsc (out_vld drives lz, out_rdy comes from vz).

Parameters:
- WIDTH, 128, payload width of each requester and the output.
- CNT_W, 8, width of the burst-length field and the beat counter.

Ports:
- nvdla_core_clk  in  1  core clock; the only clock.
- nvdla_core_rst  in  1  reset; one clock; reset is synchronous and active-high.
- cfg_burst_len  in  CNT_W  beats per grant minus one (0 = 1 beat, 255 = 256 beats).
- req0_vld  in  1  requester 0 (mul) beat valid.
- req0_rdy  out  1  requester 0 beat accepted this cycle when high with req0_vld.
- req0_pd  in  WIDTH  requester 0 payload.
- req1_vld  in  1  requester 1 (bypass) beat valid.
- req1_rdy  out  1  requester 1 beat accepted this cycle when high with req1_vld.
- req1_pd  in  WIDTH  requester 1 payload.
- out_vld  out  1  output register holds a valid beat (to rsc lz).
- out_rdy  in  1  consumer takes the beat this cycle (from rsc vz).
- out_pd  out  WIDTH  output payload (to rsc z).
- out_src  out  1  source of the current out_pd (0 = req0, 1 = req1).
- arb_busy  out  1  high while in a GRANT state.

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1.
  - Registers: state, rr_ptr (1 bit, the requester to favour next), beat_cnt (CNT_W), len_q (CNT_W).
- Reset values: state=IDLE, rr_ptr=0, beat_cnt=0, len_q=0, out_vld=0, out_pd=0, out_src=0, arb_busy=0, req*_rdy=0.
- IDLE arbitration:
  - Only req0_vld → GRANT0.
  - Only req1_vld → GRANT1.
  - Both valid → GRANTrr_ptr.
  - Neither valid → stay in IDLE.
  - On a grant: len_q<=cfg_burst_len, beat_cnt<=0. cfg_burst_len is sampled only here; changes mid-burst are ignored.
  - Arbitration costs one cycle: no beat is accepted while in IDLE.
- Ready rule: stage_free = !out_vld || out_rdy.
  - GRANTn: reqn_rdy = stage_free; the other requester's rdy = 0.
  - IDLE: both rdy = 0.
  - rdy is combinational from state, out_vld and out_rdy; it must not depend on reqn_vld.
- Beat acceptance (reqn_vld && reqn_rdy) at cycle t:
  - out_pd<=reqn_pd, out_src<=n, out_vld<=1 at edge t+1.
  - Latency is one cycle; throughput is one beat per cycle under continuous out_rdy.
- Output hold: out_vld && !out_rdy holds out_pd, out_src and out_vld stable.
  - out_vld clears only when out_rdy is high and no new beat is accepted in the same cycle.
- Counting and grant release:
  - beat_cnt increments per accepted beat.
  - If the beat is accepted with beat_cnt==len_q (last beat): state<=IDLE, rr_ptr<=!n, beat_cnt<=0.
  - A granted requester that deasserts vld mid-burst keeps the grant (no timeout). The burst completes only after len_q+1 beats.
- Simultaneous events:
  - Last beat accepted while the other requester is valid: one IDLE cycle follows, then the other requester is granted.
  - out_rdy plus a new acceptance in the same cycle: out_vld stays 1 and out_pd updates.
- Wrap: len_q=255 gives 256 beats; beat_cnt never exceeds len_q and never wraps.
- Reset mid-burst: everything returns to reset values at the next edge and the in-flight output beat is dropped.
- arb_busy = (state != IDLE).

Decomposition:
- Shared package sdp_y_arb_pkg holds:
  - state enum (IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2);
  - WIDTH and CNT_W defaults;
  - requester index constants.
- One sub-module, sdp_y_out_stage: the one-entry valid/ready register (load, hold, clear). The FSM, counter and mux stay in the top.

Test Plan:
- Reset: hold nvdla_core_rst 2 cycles with req0_vld=req1_vld=1 → out_vld=0, out_pd=0, req*_rdy=0. First rdy is req0_rdy=1 on the 2nd cycle after release (IDLE then GRANT0).
- Single burst: cfg_burst_len=3, req0 streams pd=1,2,3,4, out_rdy=1 → out_pd=1..4 on consecutive cycles each one cycle after acceptance, out_src=0. FSM returns to IDLE after the 4th beat and rr_ptr=1.
- Round-robin: both vld, cfg_burst_len=1 → grant order req0(2 beats), IDLE, req1(2 beats), IDLE, req0. out_src follows 0,0,1,1,0.
- Backpressure: out_rdy=0 for 5 cycles mid-burst with pd=0xA5.. → out_pd holds 0xA5.., req0_rdy=0 throughout. The next beat is accepted in the same cycle out_rdy returns to 1, with no beat lost or duplicated.
- Max length: cfg_burst_len=255 → exactly 256 beats before release. Changing cfg_burst_len to 0 mid-burst has no effect.
- Mid-burst reset: assert reset after beat 2 of 4 with out_vld=1 → next cycle out_vld=0, state IDLE, rr_ptr=0, beat_cnt=0.
